// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: adds two W-bit operands one 4-bit digit per cycle through an external 4-bit CLA (optional subtract via CLA_SEQ_SUB_EN)
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 Sub,
`endif
    output logic [3:0]           NibX,
    output logic [3:0]           NibY,
    output logic                 NibC,
    input  logic [3:0]           NibS,
    input  logic                 NibCout,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 Cout,
    output logic                 Ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic            sub_w;

`ifdef CLA_SEQ_SUB_EN
    assign sub_w = Sub;
`else
    assign sub_w = 1'b0;
`endif

    // Digit path to the external CLA is live only while running; B is stored pre-inverted for subtraction
    always_comb begin
        NibX     = (state_q == RUN) ? a_q[4*k_q +: 4] : 4'd0;
        NibY     = (state_q == RUN) ? b_q[4*k_q +: 4] : 4'd0;
        NibC     = (state_q == RUN) ? carry_q : 1'b0;
        InReady  = (state_q == IDLE) && !Rst;
        OutValid = (state_q == DONE);
        Sum      = sum_q;
        Cout     = cout_q;
        Ovf      = ovf_q;
    end

    // Sequencer: capture operands, step one digit per clock, hold result until consumed
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (InValid) begin
                    a_q     <= A;
                    b_q     <= sub_w ? ~B : B;
                    carry_q <= sub_w ? 1'b1 : Cin;
                    k_q     <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[4*k_q +: 4] <= NibS;
                    carry_q           <= NibCout;
                    k_q               <= k_q + 1'b1;
                    if (k_q == KW'(NIBBLES - 1)) begin
                        cout_q  <= NibCout;
                        ovf_q   <= (NibX[3] == NibY[3]) && (NibS[3] != NibX[3]);
                        k_q     <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: if (OutReady) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb_cla_nibble_sequencer: directed vectors checked against an arithmetic reference model every cycle
module tb_cla_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         InValid = 1'b0;
    logic         Cin = 1'b0;
    logic         OutReady = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
`ifdef CLA_SEQ_SUB_EN
    logic         Sub = 1'b0;
`endif
    logic         InReady, OutValid, Cout, Ovf, NibC, NibCout;
    logic [3:0]   NibX, NibY, NibS;
    logic [W-1:0] Sum;

    cla_nibble_sequencer #(.NIBBLES(N)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Cin(Cin),
`ifdef CLA_SEQ_SUB_EN
        .Sub(Sub),
`endif
        .NibX(NibX), .NibY(NibY), .NibC(NibC), .NibS(NibS), .NibCout(NibCout),
        .OutValid(OutValid), .OutReady(OutReady), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    // external 4-bit adder standing in for the CLA
    assign {NibCout, NibS} = NibX + NibY + {3'b000, NibC};

    always #10 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: phase 0 idle, 1 running digit mj, 2 result held
    int           ph = 0;
    int           mj = 0;
    logic [W-1:0] ma = '0, mb = '0, msum = '0;
    logic         mc = 1'b0, mcout = 1'b0, movf = 1'b0;

    function automatic logic carry_into(input int j);
        logic [W:0] m;
        logic [W:0] t;
        m = (W+1)'(1) << (4*j);
        m = m - 1'b1;
        t = ({1'b0, ma} & m) + ({1'b0, mb} & m) + {{W{1'b0}}, mc};
        return t[4*j];
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ph = 0; mj = 0; msum = '0; mcout = 1'b0; movf = 1'b0;
        end else if (ph == 0) begin
            if (InValid) begin
                logic s;
`ifdef CLA_SEQ_SUB_EN
                s = Sub;
`else
                s = 1'b0;
`endif
                ma = A;
                mb = s ? ~B : B;
                mc = s ? 1'b1 : Cin;
                mj = 0;
                ph = 1;
            end
        end else if (ph == 1) begin
            if (mj == N-1) begin
                {mcout, msum} = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
                movf = (ma[W-1] == mb[W-1]) && (msum[W-1] != ma[W-1]);
                ph = 2;
            end else mj++;
        end else if (OutReady) ph = 0;
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("in_ready", {31'd0, InReady}, {31'd0, (ph == 0) && !Rst});
            chk("out_valid", {31'd0, OutValid}, {31'd0, ph == 2});
            if (ph == 1) begin
                chk("nib_x", {28'd0, NibX}, 32'((ma >> (4*mj)) & 16'hF));
                chk("nib_y", {28'd0, NibY}, 32'((mb >> (4*mj)) & 16'hF));
                chk("nib_c", {31'd0, NibC}, {31'd0, carry_into(mj)});
            end else begin
                chk("nib_idle", {23'd0, NibX, NibY, NibC}, 32'd0);
                chk("sum", {16'd0, Sum}, {16'd0, msum});
                chk("cout", {31'd0, Cout}, {31'd0, mcout});
                chk("ovf", {31'd0, Ovf}, {31'd0, movf});
            end
        end
    end

    // called at posedge+2 with the block idle
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input logic [W-1:0] es, input logic ec, input logic eo, input int hold);
        int lat;
        A = a; B = b; Cin = ci;
`ifdef CLA_SEQ_SUB_EN
        Sub = sb;
`else
        if (sb) $display("note: subtract vector skipped");
`endif
        InValid = 1'b1;
        @(posedge Clk);
        #2 InValid = 1'b0;
        lat = 0;
        do begin
            @(posedge Clk);
            #1 lat++;
        end while (!OutValid && lat < 10);
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_sum"}, {16'd0, Sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, Cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, Ovf}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #2 InValid = 1'b1;
            A = ~a; B = a;
            #1 chk({nm, "_hold_valid"}, {31'd0, OutValid}, 32'd1);
            chk({nm, "_hold_sum"}, {16'd0, Sum}, {16'd0, es});
        end
        @(posedge Clk);
        #2 InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk);
        #2 OutReady = 1'b0;
        chk({nm, "_back_idle"}, {31'd0, InReady}, 32'd1);
    endtask

    initial begin
        #5 Rst = 1'b1;
        @(posedge Clk);
        #1 cmp_en = 1'b1;
        chk("rst_sum", {16'd0, Sum}, 32'd0);
        chk("rst_out_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_nib", {23'd0, NibX, NibY, NibC}, 32'd0);
        #1 Rst = 1'b0;
        @(posedge Clk);
        #2 chk("rst_in_ready", {31'd0, InReady}, 32'd1);

        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5);
        run_op("cin",      16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1);

        A = 16'h1234; B = 16'h4321; Cin = 1'b0;
        InValid = 1'b1;
        @(posedge Clk);
        #2 InValid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1 chk("midrun_rst_sum", {16'd0, Sum}, 32'd0);
        chk("midrun_rst_valid", {31'd0, OutValid}, 32'd0);
        chk("midrun_rst_nib", {23'd0, NibX, NibY, NibC}, 32'd0);
        chk("midrun_rst_cout", {31'd0, Cout, Ovf}, 32'd0);
        @(posedge Clk);
        #2 Rst = 1'b0;
        repeat (6) @(posedge Clk);
        #2 chk("midrun_no_valid", {31'd0, OutValid}, 32'd0);
        run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
        run_op("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        Sub = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
